imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Debug-side writer for the instruction BRAM port that fetch reads from.
//  Parses a framed byte stream from the debug link into 32-bit words and writes them into instruction memory.
//  Holds the CPU front end (drives fetch c_flush) while a frame is in progress.
//  Sits between the debug byte link and the BRAM write port (BRAM addressed by m_addr[31:2]).
// PARAMETERS
//  MEM_BYTES  32'h0001_0000  instruction memory size in bytes; writes at or above this address abort the frame
//  SYNC_BYTE  8'hA5          frame start marker
//  TIMEOUT    1024           max idle cycles between bytes inside a frame before abort
// PORTS
//  clk         in   1   core clock
//  rst_n       in   1   asynchronous active-low reset
//  s_data      in   8   debug link byte
//  s_valid     in   1   s_data valid
//  s_ready     out  1   byte accepted when s_valid && s_ready
//  m_addr      out  32  BRAM byte address, word aligned
//  m_wdata     out  32  BRAM write data
//  m_en        out  1   BRAM enable
//  m_we        out  1   BRAM write enable
//  o_cpu_hold  out  1   hold/flush to fetch while loading
//  o_done      out  1   1-cycle pulse: frame fully written
//  o_err       out  1   1-cycle pulse: frame aborted
// BEHAVIOUR
//  Reset: FSM=IDLE; s_ready=1; m_addr=0, m_wdata=0, m_en=0, m_we=0, o_cpu_hold=0, o_done=0, o_err=0.
//  Frame: SYNC, ADDR[7:0..31:24] (4 bytes LE), CNT[7:0..15:8] (2 bytes LE), then CNT words, each 4 bytes LE.
//  States: IDLE -> ADDR -> CNT -> DATA <-> WRITE -> DONE -> IDLE.
//  IDLE: non-SYNC bytes discarded silently; SYNC -> ADDR, o_cpu_hold=1 from next cycle.
//  ADDR: after 4th byte, if addr[1:0]!=0 -> abort; else CNT.
//  CNT: after 2nd byte, CNT==0 -> DONE directly; else DATA.
//  DATA: shift bytes into word; 4th byte accepted at cycle N -> WRITE at N+1.
//  WRITE: exactly one cycle, m_en=m_we=1, m_addr/m_wdata stable; s_ready=0.
//    Then addr+=4 (32-bit wrap), remaining--; remaining==0 -> DONE else DATA.
//  Address check before each WRITE: addr>=MEM_BYTES -> abort, no write issued.
//  DONE: one cycle, o_done=1, s_ready=0; o_cpu_hold drops the following cycle (IDLE).
//  Abort: o_err=1 for one cycle, return to IDLE, o_cpu_hold=0 next cycle; words already written stay written.
//  Timeout: counter clears on every accepted byte in ADDR/CNT/DATA; reaching TIMEOUT -> abort.
//  s_ready=1 in IDLE/ADDR/CNT/DATA, 0 in WRITE/DONE; m_en/m_we=0 outside WRITE.
//  SYNC byte value inside a frame is ordinary data (no resync).
//  rst_n low mid-frame: immediate return to reset values, no partial write, no o_err.
// STRUCTURE
//  Shared package: FSM state enum, SYNC_BYTE default, frame field byte counts.
//  One sub-module natural: imem_loader_wordpack (byte-to-word LE shift + byte index).
//  Timeout counter and address/count registers inline.
// TESTING
//  Frame A5,00,01,00,00,02,00, 11,22,33,44, 55,66,77,88 -> writes 0x44332211@0x100, 0x88776655@0x104, o_done once.
//  Count 0 frame A5,00,02,00,00,00,00 -> no m_we, o_done 1 cycle, o_cpu_hold high 7..8 cycles total.
//  Address 0x0000_0102 -> o_err pulse after 5th byte, no write, back to IDLE.
//  Start addr MEM_BYTES-4, CNT=2 -> first word written, o_err before second write.
//  Gap of TIMEOUT cycles after 3rd data byte -> o_err, IDLE, no write; next good frame succeeds.
//  rst_n low during DATA -> all outputs reset value asynchronously; following frame loads correctly.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM states and frame field sizes for the instruction memory loader
package imem_loader_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_CNT, S_DATA, S_WRITE, S_DONE} state_t;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam int ADDR_BYTES = 4;
  localparam int CNT_BYTES = 2;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/imem_loader_wordpack.sv
// imem_loader_wordpack: little-endian byte-to-word shifter with byte index
module imem_loader_wordpack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        shift,
  input  logic [7:0]  din,
  output logic [31:0] word_nxt,
  output logic [1:0]  idx
);
  logic [23:0] word;
  assign word_nxt = {din, word};
  // newest byte enters at the top so the first byte ends up in bits [7:0]
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      word <= '0;
      idx  <= '0;
    end else if (clr) begin
      word <= '0;
      idx  <= '0;
    end else if (shift) begin
      word <= word_nxt[31:8];
      idx  <= idx + 2'd1;
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: parses framed debug bytes into 32-bit words and writes them to instruction BRAM
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] MEM_BYTES = 32'h0001_0000,
  parameter logic [7:0]  SYNC_BYTE = SYNC_DEFAULT,
  parameter int          TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_en,
  output logic        m_we,
  output logic        o_cpu_hold,
  output logic        o_done,
  output logic        o_err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [31:0] addr;
  logic [15:0] rem;
  logic [TW-1:0] tmo;
  logic acc, in_frame, tmo_hit, pk_clr;
  logic [31:0] pk_word;
  logic [1:0] pk_idx;
  assign acc = s_valid && s_ready;
  assign in_frame = state inside {S_ADDR, S_CNT, S_DATA};
  assign tmo_hit = in_frame && !acc && (tmo == TW'(TIMEOUT - 1));
  assign pk_clr = state == S_IDLE || (state == S_CNT && acc && pk_idx == 2'(CNT_BYTES - 1));
  imem_loader_wordpack u_pack (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (pk_clr),
    .shift   (acc && in_frame),
    .din     (s_data),
    .word_nxt(pk_word),
    .idx     (pk_idx)
  );
  // frame FSM; every output is registered and any abort lands back in IDLE with hold released
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= S_IDLE;
      s_ready    <= 1'b1;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_en       <= 1'b0;
      m_we       <= 1'b0;
      o_cpu_hold <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      addr       <= '0;
      rem        <= '0;
      tmo        <= '0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      m_en   <= 1'b0;
      m_we   <= 1'b0;
      tmo    <= (in_frame && !acc) ? tmo + 1'b1 : '0;
      if (tmo_hit) begin
        state      <= S_IDLE;
        o_err      <= 1'b1;
        o_cpu_hold <= 1'b0;
      end else
        case (state)
          S_IDLE:
            if (acc && s_data == SYNC_BYTE) begin
              state      <= S_ADDR;
              o_cpu_hold <= 1'b1;
            end
          S_ADDR:
            if (acc && pk_idx == 2'(ADDR_BYTES - 1)) begin
              addr <= pk_word;
              if (pk_word[1:0] != 2'b00) begin
                state      <= S_IDLE;
                o_err      <= 1'b1;
                o_cpu_hold <= 1'b0;
              end else
                state <= S_CNT;
            end
          S_CNT:
            if (acc && pk_idx == 2'(CNT_BYTES - 1)) begin
              rem <= pk_word[31:16];
              if (pk_word[31:16] == 16'd0) begin
                state   <= S_DONE;
                o_done  <= 1'b1;
                s_ready <= 1'b0;
              end else
                state <= S_DATA;
            end
          S_DATA:
            if (acc && pk_idx == 2'(WORD_BYTES - 1)) begin
              if (addr >= MEM_BYTES) begin
                state      <= S_IDLE;
                o_err      <= 1'b1;
                o_cpu_hold <= 1'b0;
              end else begin
                state   <= S_WRITE;
                m_en    <= 1'b1;
                m_we    <= 1'b1;
                m_addr  <= addr;
                m_wdata <= pk_word;
                s_ready <= 1'b0;
              end
            end
          S_WRITE: begin
            addr <= addr + 32'd4;
            rem  <= rem - 16'd1;
            if (rem == 16'd1) begin
              state  <= S_DONE;
              o_done <= 1'b1;
            end else begin
              state   <= S_DATA;
              s_ready <= 1'b1;
            end
          end
          S_DONE: begin
            state      <= S_IDLE;
            o_cpu_hold <= 1'b0;
            s_ready    <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed scenario checks for the instruction memory loader
module tb_imem_loader;
  localparam int TIMEOUT = 1024;
  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] s_data;
  logic s_valid;
  logic s_ready;
  logic [31:0] m_addr, m_wdata;
  logic m_en, m_we, o_cpu_hold, o_done, o_err;
  int tests = 0;
  int fails = 0;
  int wr_cnt = 0, done_cnt = 0, err_cnt = 0, hold_cnt = 0, ready_viol = 0;
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];

  imem_loader #(.MEM_BYTES(32'h0001_0000), .SYNC_BYTE(8'hA5), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_en(m_en), .m_we(m_we),
    .o_cpu_hold(o_cpu_hold), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  // observe registered outputs mid-cycle
  always @(negedge clk) begin
    if (m_en && m_we) begin
      if (wr_cnt < 64) begin
        wr_addr[wr_cnt] = m_addr;
        wr_data[wr_cnt] = m_wdata;
      end
      wr_cnt++;
      if (s_ready) ready_viol++;
    end
    if (o_done) done_cnt++;
    if (o_err) err_cnt++;
    if (o_cpu_hold) hold_cnt++;
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data = b;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("FAIL send_byte: s_ready stuck at %b, required 1", s_ready);
    end
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [31:0] a, input logic [15:0] c);
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < 2; i++) send_byte(c[8*i +: 8]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_data = 8'h00;
    repeat (3) @(negedge clk);
    tests++;
    if ({s_ready, m_en, m_we, o_cpu_hold, o_done, o_err} !== 6'b100000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b required 100000", {s_ready, m_en, m_we, o_cpu_hold, o_done, o_err});
    end
    tests++;
    if ({m_addr, m_wdata} !== 64'd0) begin
      fails++;
      $display("FAIL reset_bus: got %h/%h required 0/0", m_addr, m_wdata);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame;
    int w0, d0, e0;
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    send_byte(8'h00);
    send_byte(8'h5A);
    tests++;
    if (o_cpu_hold !== 1'b0) begin
      fails++;
      $display("FAIL idle_discard: hold %b required 0", o_cpu_hold);
    end
    send_hdr(32'h0000_0100, 16'd2);
    send_word(32'h4433_2211);
    send_word(32'h8877_6655);
    repeat (4) @(negedge clk);
    tests++;
    if (wr_cnt - w0 !== 2) begin
      fails++;
      $display("FAIL frame_writes: got %0d required 2", wr_cnt - w0);
    end
    tests++;
    if (wr_addr[w0] !== 32'h100 || wr_data[w0] !== 32'h4433_2211) begin
      fails++;
      $display("FAIL frame_word0: got %h@%h required 44332211@00000100", wr_data[w0], wr_addr[w0]);
    end
    tests++;
    if (wr_addr[w0+1] !== 32'h104 || wr_data[w0+1] !== 32'h8877_6655) begin
      fails++;
      $display("FAIL frame_word1: got %h@%h required 88776655@00000104", wr_data[w0+1], wr_addr[w0+1]);
    end
    tests++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
      fails++;
      $display("FAIL frame_status: done %0d err %0d required 1 0", done_cnt - d0, err_cnt - e0);
    end
    tests++;
    if (o_cpu_hold !== 1'b0 || ready_viol !== 0) begin
      fails++;
      $display("FAIL frame_end: hold %b ready_viol %0d required 0 0", o_cpu_hold, ready_viol);
    end
  endtask

  task automatic test_count0;
    int w0, d0, h0;
    w0 = wr_cnt; d0 = done_cnt; h0 = hold_cnt;
    send_hdr(32'h0000_0200, 16'd0);
    repeat (4) @(negedge clk);
    tests++;
    if (wr_cnt - w0 !== 0 || done_cnt - d0 !== 1) begin
      fails++;
      $display("FAIL count0: writes %0d done %0d required 0 1", wr_cnt - w0, done_cnt - d0);
    end
    tests++;
    if (hold_cnt - h0 < 7 || hold_cnt - h0 > 8) begin
      fails++;
      $display("FAIL count0_hold: got %0d cycles required 7..8", hold_cnt - h0);
    end
  endtask

  task automatic test_misaligned;
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    tests++;
    if (o_err !== 1'b1) begin
      fails++;
      $display("FAIL misalign_pulse: o_err %b required 1", o_err);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (err_cnt - e0 !== 1 || wr_cnt - w0 !== 0 || o_cpu_hold !== 1'b0) begin
      fails++;
      $display("FAIL misalign: err %0d writes %0d hold %b required 1 0 0", err_cnt - e0, wr_cnt - w0, o_cpu_hold);
    end
  endtask

  task automatic test_mem_limit;
    int w0, e0, d0;
    w0 = wr_cnt; e0 = err_cnt; d0 = done_cnt;
    send_hdr(32'h0000_FFFC, 16'd2);
    send_word(32'hDEAD_BEEF);
    send_word(32'h1234_5678);
    repeat (3) @(negedge clk);
    tests++;
    if (wr_cnt - w0 !== 1 || wr_addr[w0] !== 32'h0000_FFFC || wr_data[w0] !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL limit_write: n %0d got %h@%h required 1 deadbeef@0000fffc", wr_cnt - w0, wr_data[w0], wr_addr[w0]);
    end
    tests++;
    if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
      fails++;
      $display("FAIL limit_err: err %0d done %0d required 1 0", err_cnt - e0, done_cnt - d0);
    end
  endtask

  task automatic test_timeout;
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    send_hdr(32'h0000_0300, 16'd1);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    repeat (TIMEOUT - 1) @(posedge clk);
    @(negedge clk);
    tests++;
    if (err_cnt - e0 !== 0) begin
      fails++;
      $display("FAIL timeout_early: err %0d required 0", err_cnt - e0);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (err_cnt - e0 !== 1 || wr_cnt - w0 !== 0 || o_cpu_hold !== 1'b0) begin
      fails++;
      $display("FAIL timeout: err %0d writes %0d hold %b required 1 0 0", err_cnt - e0, wr_cnt - w0, o_cpu_hold);
    end
    w0 = wr_cnt;
    send_hdr(32'h0000_0300, 16'd1);
    send_word(32'hCAFE_F00D);
    repeat (3) @(negedge clk);
    tests++;
    if (wr_cnt - w0 !== 1 || wr_addr[w0] !== 32'h300 || wr_data[w0] !== 32'hCAFE_F00D) begin
      fails++;
      $display("FAIL timeout_recover: n %0d got %h@%h required 1 cafef00d@00000300", wr_cnt - w0, wr_data[w0], wr_addr[w0]);
    end
  endtask

  task automatic test_sync_in_data;
    int w0;
    w0 = wr_cnt;
    send_hdr(32'h0000_0180, 16'd1);
    send_word(32'hA5A5_A5A5);
    repeat (3) @(negedge clk);
    tests++;
    if (wr_cnt - w0 !== 1 || wr_addr[w0] !== 32'h180 || wr_data[w0] !== 32'hA5A5_A5A5) begin
      fails++;
      $display("FAIL sync_data: n %0d got %h@%h required 1 a5a5a5a5@00000180", wr_cnt - w0, wr_data[w0], wr_addr[w0]);
    end
  endtask

  task automatic test_reset_mid;
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    send_hdr(32'h0000_0400, 16'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({s_ready, m_en, m_we, o_cpu_hold, o_done, o_err} !== 6'b100000 || {m_addr, m_wdata} !== 64'd0) begin
      fails++;
      $display("FAIL async_reset: ctrl %b bus %h/%h required 100000 0/0", {s_ready, m_en, m_we, o_cpu_hold, o_done, o_err}, m_addr, m_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (wr_cnt - w0 !== 0 || err_cnt - e0 !== 0) begin
      fails++;
      $display("FAIL reset_side: writes %0d err %0d required 0 0", wr_cnt - w0, err_cnt - e0);
    end
    send_hdr(32'h0000_0400, 16'd1);
    send_word(32'h0102_0304);
    repeat (3) @(negedge clk);
    tests++;
    if (wr_cnt - w0 !== 1 || wr_addr[w0] !== 32'h400 || wr_data[w0] !== 32'h0102_0304) begin
      fails++;
      $display("FAIL reset_recover: n %0d got %h@%h required 1 01020304@00000400", wr_cnt - w0, wr_data[w0], wr_addr[w0]);
    end
  endtask

  initial begin
    test_reset;
    test_frame;
    test_count0;
    test_misaligned;
    test_mem_limit;
    test_timeout;
    test_sync_in_data;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
